ctrl_pipe_mem_wb: RTL and testbench

Downstream neighbour of the ID/EX control decoder. Carries the decoded control bundle and destination register through the EX/MEM and MEM/WB pipeline registers. Supports stall and kill (bubble insertion). Generates operand-forwarding selects and a load-use hazard flag for the EX-stage ALU muxes and the upstream hazard logic.

---
 rtl/ctrl_pipe_pkg.sv | 20 ++
 rtl/ctrl_pipe_mem_wb_fwd_unit.sv | 52 +++++
 rtl/ctrl_pipe_mem_wb.sv | 118 +++++++++++
 tb/tb_ctrl_pipe_mem_wb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control pipeline: opcodes, forward-select codes
// and the register-index width used by the decoder and the EX/MEM/WB stages.
package ctrl_pipe_pkg;

    localparam int REG_AW = 5;

    // RV32 major opcodes, kept in sync with the ID/EX decoder
    localparam logic [6:0] RRAI = 7'b0110011;
    localparam logic [6:0] RIAI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] CBI  = 7'b1100011;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ctrl_pipe_mem_wb_fwd_unit.sv
// Combinational operand-forward selects and load-use hazard detection,
// driven from the registered EX/MEM and MEM/WB state and the EX sources.
module fwd_unit #(
    parameter int REG_AW = ctrl_pipe_pkg::REG_AW
) (
    input  logic              RegWrite_EX_MEM,
    input  logic              MemRead_EX_MEM,
    input  logic [REG_AW-1:0] Rd_EX_MEM,
    input  logic              RegWrite_MEM_WB,
    input  logic [REG_AW-1:0] Rd_MEM_WB,
    input  logic [REG_AW-1:0] Rs1_ID_EX,
    input  logic [REG_AW-1:0] Rs2_ID_EX,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              LoadUseHaz
);
    import ctrl_pipe_pkg::*;

    logic exLive, wbLive;
    logic exHitA, exHitB, wbHitA, wbHitB;

    // x0 is hard-wired zero, so a write to it is never a forwarding source
    assign exLive = RegWrite_EX_MEM & (Rd_EX_MEM != '0);
    assign wbLive = RegWrite_MEM_WB & (Rd_MEM_WB != '0);

    assign exHitA = exLive & (Rd_EX_MEM == Rs1_ID_EX);
    assign exHitB = exLive & (Rd_EX_MEM == Rs2_ID_EX);
    assign wbHitA = wbLive & (Rd_MEM_WB == Rs1_ID_EX);
    assign wbHitB = wbLive & (Rd_MEM_WB == Rs2_ID_EX);

    // EX/MEM holds the younger result, so it takes priority over MEM/WB
    always_comb begin
        ForwardA = FWD_RF;
        if (exHitA)
            ForwardA = FWD_EXMEM;
        else if (wbHitA)
            ForwardA = FWD_MEMWB;
    end

    always_comb begin
        ForwardB = FWD_RF;
        if (exHitB)
            ForwardB = FWD_EXMEM;
        else if (wbHitB)
            ForwardB = FWD_MEMWB;
    end

    // Load data is not available until MEM/WB, so an EX/MEM hit on a load
    // cannot be forwarded and needs a bubble instead
    assign LoadUseHaz = MemRead_EX_MEM & (exHitA | exHitB);

endmodule

// File: rtl/ctrl_pipe_mem_wb.sv
// EX/MEM and MEM/WB control pipeline registers with stall/kill, forwarding
// and load-use detection. Optional retire counter: CTRL_PIPE_RETIRE_CNT_EN.
module ctrl_pipe_mem_wb #(
    parameter int REG_AW = ctrl_pipe_pkg::REG_AW
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              RegWrite_ID_EX,
    input  logic              PCWriteCond_ID_EX,
    input  logic              MemRead_ID_EX,
    input  logic              MemWrite_ID_EX,
    input  logic              MemtoReg_ID_EX,
    input  logic              IRWrite_ID_EX,
    input  logic [REG_AW-1:0] Rd_ID_EX,
    input  logic [REG_AW-1:0] Rs1_ID_EX,
    input  logic [REG_AW-1:0] Rs2_ID_EX,
    input  logic              BrTaken_EX,
    input  logic              Stall,
    input  logic              Kill_EX,
    output logic              RegWrite_EX_MEM,
    output logic              MemRead_EX_MEM,
    output logic              MemWrite_EX_MEM,
    output logic              MemtoReg_EX_MEM,
    output logic [REG_AW-1:0] Rd_EX_MEM,
    output logic              Valid_EX_MEM,
    output logic              PCSrc_EX_MEM,
    output logic              RegWrite_MEM_WB,
    output logic              MemtoReg_MEM_WB,
    output logic [REG_AW-1:0] Rd_MEM_WB,
    output logic              Valid_MEM_WB,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              LoadUseHaz
`ifdef CTRL_PIPE_RETIRE_CNT_EN
    ,
    output logic [31:0]       RetireCnt
`endif
);
    import ctrl_pipe_pkg::*;

    logic exAdvance;
    logic wbAdvance;
    logic regWriteNext;

    // Kill overrides Stall for EX/MEM: the bubble must land even while frozen
    assign exAdvance    = ~Stall & ~Kill_EX;
    assign wbAdvance    = ~Stall;
    assign regWriteNext = RegWrite_ID_EX & IRWrite_ID_EX & (Rd_ID_EX != '0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Valid_EX_MEM    <= 1'b0;
            RegWrite_EX_MEM <= 1'b0;
            MemRead_EX_MEM  <= 1'b0;
            MemWrite_EX_MEM <= 1'b0;
            MemtoReg_EX_MEM <= 1'b0;
            PCSrc_EX_MEM    <= 1'b0;
            Rd_EX_MEM       <= '0;
        end else if (Kill_EX) begin
            Valid_EX_MEM    <= 1'b0;
            RegWrite_EX_MEM <= 1'b0;
            MemRead_EX_MEM  <= 1'b0;
            MemWrite_EX_MEM <= 1'b0;
            MemtoReg_EX_MEM <= 1'b0;
            PCSrc_EX_MEM    <= 1'b0;
            Rd_EX_MEM       <= '0;
        end else if (exAdvance) begin
            Valid_EX_MEM    <= IRWrite_ID_EX;
            RegWrite_EX_MEM <= regWriteNext;
            MemRead_EX_MEM  <= MemRead_ID_EX & IRWrite_ID_EX;
            MemWrite_EX_MEM <= MemWrite_ID_EX & IRWrite_ID_EX;
            MemtoReg_EX_MEM <= MemtoReg_ID_EX & IRWrite_ID_EX;
            PCSrc_EX_MEM    <= PCWriteCond_ID_EX & BrTaken_EX & IRWrite_ID_EX;
            Rd_EX_MEM       <= Rd_ID_EX;
        end
    end

    // Memory-access controls are consumed in MEM and not carried further
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Valid_MEM_WB    <= 1'b0;
            RegWrite_MEM_WB <= 1'b0;
            MemtoReg_MEM_WB <= 1'b0;
            Rd_MEM_WB       <= '0;
        end else if (wbAdvance) begin
            Valid_MEM_WB    <= Valid_EX_MEM;
            RegWrite_MEM_WB <= RegWrite_EX_MEM;
            MemtoReg_MEM_WB <= MemtoReg_EX_MEM;
            Rd_MEM_WB       <= Rd_EX_MEM;
        end
    end

`ifdef CTRL_PIPE_RETIRE_CNT_EN
    // An instruction retires when it leaves MEM/WB on a moving edge
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            RetireCnt <= '0;
        else if (wbAdvance && Valid_MEM_WB)
            RetireCnt <= RetireCnt + 32'd1;
    end
`endif

    fwd_unit #(
        .REG_AW (REG_AW)
    ) uFwd (
        .RegWrite_EX_MEM (RegWrite_EX_MEM),
        .MemRead_EX_MEM  (MemRead_EX_MEM),
        .Rd_EX_MEM       (Rd_EX_MEM),
        .RegWrite_MEM_WB (RegWrite_MEM_WB),
        .Rd_MEM_WB       (Rd_MEM_WB),
        .Rs1_ID_EX       (Rs1_ID_EX),
        .Rs2_ID_EX       (Rs2_ID_EX),
        .ForwardA        (ForwardA),
        .ForwardB        (ForwardB),
        .LoadUseHaz      (LoadUseHaz)
    );

endmodule

// File: tb/tb_ctrl_pipe_mem_wb.sv
// Directed and random checks of ctrl_pipe_mem_wb against a stage-record model.
module tb_ctrl_pipe_mem_wb;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       pc;
        logic [4:0] rd;
    } stT;

    logic       CLK, RSTn;
    logic       RegWrite_ID_EX, PCWriteCond_ID_EX, MemRead_ID_EX, MemWrite_ID_EX;
    logic       MemtoReg_ID_EX, IRWrite_ID_EX, BrTaken_EX, Stall, Kill_EX;
    logic [4:0] Rd_ID_EX, Rs1_ID_EX, Rs2_ID_EX;
    logic       RegWrite_EX_MEM, MemRead_EX_MEM, MemWrite_EX_MEM, MemtoReg_EX_MEM;
    logic [4:0] Rd_EX_MEM, Rd_MEM_WB;
    logic       Valid_EX_MEM, PCSrc_EX_MEM, RegWrite_MEM_WB, MemtoReg_MEM_WB, Valid_MEM_WB;
    logic [1:0] ForwardA, ForwardB;
    logic       LoadUseHaz;
`ifdef CTRL_PIPE_RETIRE_CNT_EN
    logic [31:0] RetireCnt;
`endif

    int checks = 0;
    int errors = 0;
    stT em, mw;
    int unsigned cnt;
    stT obsEm, obsMw;

    assign obsEm = {Valid_EX_MEM, RegWrite_EX_MEM, MemRead_EX_MEM, MemWrite_EX_MEM,
                    MemtoReg_EX_MEM, PCSrc_EX_MEM, Rd_EX_MEM};
    assign obsMw = {Valid_MEM_WB, RegWrite_MEM_WB, 1'b0, 1'b0, MemtoReg_MEM_WB, 1'b0, Rd_MEM_WB};

    ctrl_pipe_mem_wb dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .RegWrite_ID_EX    (RegWrite_ID_EX),
        .PCWriteCond_ID_EX (PCWriteCond_ID_EX),
        .MemRead_ID_EX     (MemRead_ID_EX),
        .MemWrite_ID_EX    (MemWrite_ID_EX),
        .MemtoReg_ID_EX    (MemtoReg_ID_EX),
        .IRWrite_ID_EX     (IRWrite_ID_EX),
        .Rd_ID_EX          (Rd_ID_EX),
        .Rs1_ID_EX         (Rs1_ID_EX),
        .Rs2_ID_EX         (Rs2_ID_EX),
        .BrTaken_EX        (BrTaken_EX),
        .Stall             (Stall),
        .Kill_EX           (Kill_EX),
        .RegWrite_EX_MEM   (RegWrite_EX_MEM),
        .MemRead_EX_MEM    (MemRead_EX_MEM),
        .MemWrite_EX_MEM   (MemWrite_EX_MEM),
        .MemtoReg_EX_MEM   (MemtoReg_EX_MEM),
        .Rd_EX_MEM         (Rd_EX_MEM),
        .Valid_EX_MEM      (Valid_EX_MEM),
        .PCSrc_EX_MEM      (PCSrc_EX_MEM),
        .RegWrite_MEM_WB   (RegWrite_MEM_WB),
        .MemtoReg_MEM_WB   (MemtoReg_MEM_WB),
        .Rd_MEM_WB         (Rd_MEM_WB),
        .Valid_MEM_WB      (Valid_MEM_WB),
        .ForwardA          (ForwardA),
        .ForwardB          (ForwardB),
        .LoadUseHaz        (LoadUseHaz)
`ifdef CTRL_PIPE_RETIRE_CNT_EN
        ,
        .RetireCnt         (RetireCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight producer of rs wins; x0 and non-writers never forward
    function automatic logic [1:0] expFwd(input logic [4:0] rs);
        stT         st[2];
        logic [1:0] code[2];
        st[0] = em; code[0] = 2'b10;
        st[1] = mw; code[1] = 2'b01;
        for (int i = 0; i < 2; i++)
            if (st[i].rw && st[i].rd != 5'd0 && st[i].rd == rs) return code[i];
        return 2'b00;
    endfunction

    function automatic logic expLuh();
        return em.mr && em.rw && em.rd != 5'd0 && (em.rd == Rs1_ID_EX || em.rd == Rs2_ID_EX);
    endfunction

    task automatic compareAll(input string tag);
        chk({tag, ".exmem"}, 32'(obsEm), 32'(em));
        chk({tag, ".memwb"}, 32'(obsMw), 32'(mw));
        chk({tag, ".fwdA"}, 32'(ForwardA), 32'(expFwd(Rs1_ID_EX)));
        chk({tag, ".fwdB"}, 32'(ForwardB), 32'(expFwd(Rs2_ID_EX)));
        chk({tag, ".luh"}, 32'(LoadUseHaz), 32'(expLuh()));
`ifdef CTRL_PIPE_RETIRE_CNT_EN
        chk({tag, ".retire"}, RetireCnt, cnt);
`endif
    endtask

    task automatic modelEdge();
        stT nEm, nMw;
        nEm = em;
        nMw = mw;
        if (!Stall) begin
            if (mw.v) cnt++;
            nMw     = '0;
            nMw.v   = em.v;
            nMw.rw  = em.rw;
            nMw.m2r = em.m2r;
            nMw.rd  = em.rd;
        end
        if (Kill_EX) nEm = '0;
        else if (!Stall) begin
            nEm.v   = IRWrite_ID_EX;
            nEm.rw  = IRWrite_ID_EX && RegWrite_ID_EX && Rd_ID_EX != 5'd0;
            nEm.mr  = IRWrite_ID_EX && MemRead_ID_EX;
            nEm.mw  = IRWrite_ID_EX && MemWrite_ID_EX;
            nEm.m2r = IRWrite_ID_EX && MemtoReg_ID_EX;
            nEm.pc  = IRWrite_ID_EX && PCWriteCond_ID_EX && BrTaken_EX;
            nEm.rd  = Rd_ID_EX;
        end
        em = nEm;
        mw = nMw;
    endtask

    task automatic modelReset();
        em  = '0;
        mw  = '0;
        cnt = 0;
    endtask

    task automatic drive(input logic irw, rw, mr, mwr, m2r, pcw, br,
                         input logic [4:0] rd, rs1, rs2, input logic st, kl);
        IRWrite_ID_EX = irw; RegWrite_ID_EX = rw; MemRead_ID_EX = mr;
        MemWrite_ID_EX = mwr; MemtoReg_ID_EX = m2r; PCWriteCond_ID_EX = pcw;
        BrTaken_EX = br; Rd_ID_EX = rd; Rs1_ID_EX = rs1; Rs2_ID_EX = rs2;
        Stall = st; Kill_EX = kl;
    endtask

    task automatic nop(input logic st);
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, st, 0);
    endtask

    // Check at the falling edge, then advance the model on the rising edge
    task automatic tick(input string tag);
        @(negedge CLK);
        compareAll(tag);
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    initial begin
        RSTn = 1'b0;
        nop(0);
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        compareAll("reset");
        chk("reset.fwdA", 32'(ForwardA), 32'd0);
        RSTn = 1'b1;

        // ADD x5 ; ADD x6,x5,x1 ; op reading x5 on rs2
        drive(1, 1, 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd2, 0, 0); tick("add5");
        drive(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd5, 5'd1, 0, 0); #1;
        chk("b2b.fwdA_exmem", 32'(ForwardA), 32'h2);
        tick("add6");
        drive(1, 1, 0, 0, 0, 0, 0, 5'd7, 5'd3, 5'd5, 0, 0); #1;
        chk("b2b.fwdB_memwb", 32'(ForwardB), 32'h1);
        tick("add7");

        // Load-use: LW x7 then a consumer of x7 on rs2
        drive(1, 1, 1, 0, 1, 0, 0, 5'd7, 5'd1, 5'd2, 0, 0); tick("lw7");
        drive(1, 1, 0, 0, 0, 0, 0, 5'd9, 5'd3, 5'd7, 0, 0); #1;
        chk("lu.haz", 32'(LoadUseHaz), 32'd1);
        drive(1, 1, 0, 0, 0, 0, 0, 5'd9, 5'd3, 5'd7, 1, 1); tick("lu.bubble");
        drive(1, 1, 0, 0, 0, 0, 0, 5'd9, 5'd3, 5'd7, 0, 0); #1;
        chk("lu.haz_clear", 32'(LoadUseHaz), 32'd0);
        chk("lu.fwdB_memwb", 32'(ForwardB), 32'h1);
        chk("lu.exmem_bubble", 32'(Valid_EX_MEM), 32'd0);
        chk("lu.memwb_held", 32'(Rd_MEM_WB), 32'd7);
        tick("lu.retry");

        // x0 destination must never become a write or forward source
        drive(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); tick("x0");
        chk("x0.regwrite", 32'(RegWrite_EX_MEM), 32'd0);
        chk("x0.fwdA", 32'(ForwardA), 32'd0);

        // Branch redirect pulse
        drive(1, 0, 0, 0, 0, 1, 1, 5'd0, 5'd1, 5'd2, 0, 0); tick("br.taken");
        chk("br.pulse", 32'(PCSrc_EX_MEM), 32'd1);
        nop(0); tick("br.after");
        chk("br.cleared", 32'(PCSrc_EX_MEM), 32'd0);
        drive(1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0); tick("br.nottaken");
        chk("br.nottaken", 32'(PCSrc_EX_MEM), 32'd0);
        drive(1, 0, 0, 0, 0, 1, 1, 5'd0, 5'd1, 5'd2, 0, 0); tick("br.taken2");
        nop(1); tick("br.stall1");
        chk("br.held1", 32'(PCSrc_EX_MEM), 32'd1);
        tick("br.stall2");
        chk("br.held2", 32'(PCSrc_EX_MEM), 32'd1);
        nop(0); tick("br.release");
        chk("br.released", 32'(PCSrc_EX_MEM), 32'd0);

        // Reset in flight, asserted and released between clock edges
        drive(1, 1, 0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd4, 0, 0); tick("fill1");
        drive(1, 1, 0, 0, 0, 0, 0, 5'd4, 5'd3, 5'd4, 0, 0); tick("fill2");
        chk("fill.valid_wb", 32'(Valid_MEM_WB), 32'd1);
        RSTn = 1'b0; #1;
        chk("rst.exmem", 32'(obsEm), 32'd0);
        chk("rst.memwb", 32'(obsMw), 32'd0);
        modelReset();
        compareAll("rst");
        #1 RSTn = 1'b1;

`ifdef CTRL_PIPE_RETIRE_CNT_EN
        // 10 instructions with 3 stalled slots interleaved
        for (int i = 0; i < 13; i++) begin
            if (i == 3 || i == 6 || i == 9) nop(1);
            else drive(1, 1, 0, 0, 0, 0, 0, 5'(i + 1), 5'd0, 5'd0, 0, 0);
            tick("ret.issue");
        end
        nop(0);
        repeat (3) tick("ret.drain");
        chk("ret.count", RetireCnt, 32'd10);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0));
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
